// File: rtl/k2red_pkg.sv
// Shared definitions for the K2-RED multiplier/reducer family.
// Holds family-wide default sizes, the iterative multiplier FSM state type
// and a constant function giving the number of digits per multiply.
package k2red_pkg;

  // Default operand width used across the family
  localparam int unsigned K2RED_W     = 32;
  // Default width of the reducer's k constant (modulus is 2^W - k)
  localparam int unsigned K2RED_M     = 16;
  // Default log2 of the number of shift-add reduction levels
  localparam int unsigned K2RED_LOG_L = 3;
  // Default digit width for the iterative multiplier
  localparam int unsigned K2RED_R     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } k2red_mul_state_e;

  // Number of R-bit digits in a W-bit multiplier operand
  function automatic int unsigned k2red_num_digits(input int unsigned w,
                                                   input int unsigned r);
    return w / r;
  endfunction

endpackage

// File: rtl/k2red_mul_digit.sv
// Combinational W x R partial-product generator.
// Ports:
//   x      - W-bit multiplicand
//   d      - R-bit multiplier digit
//   prod_c - x * d, full W+R-bit product (combinational)
module k2red_mul_digit
  import k2red_pkg::*;
#(
  parameter int unsigned W = K2RED_W,
  parameter int unsigned R = K2RED_R
) (
  input  logic [W-1:0]   x,
  input  logic [R-1:0]   d,
  output logic [W+R-1:0] prod_c
);

  localparam int unsigned PPW = W + R;

  always_comb begin : pp_gen
    prod_c = PPW'(x) * PPW'(d);
  end

endmodule

// File: rtl/k2red_mul_iter.sv
// Iterative digit-serial multiplier feeding the K2-RED reducer A input.
// Forms X*Y (2W bits) over N = W/R cycles, one R-bit digit of Y per cycle,
// with valid/ready handshakes on both sides. A is held until taken.
// Optional feature macro: K2RED_MUL_TAG_EN (adds in_tag/out_tag sideband).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (in_ready is combinational)
//   X, Y                - unsigned W-bit operands
//   out_valid/out_ready - product handshake
//   A                   - registered 2W-bit product
//   in_tag/out_tag      - sideband tag, only with K2RED_MUL_TAG_EN
module k2red_mul_iter
  import k2red_pkg::*;
#(
  parameter int unsigned W     = K2RED_W,
  parameter int unsigned R     = K2RED_R,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef K2RED_MUL_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     X,
  input  logic [W-1:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   A
);

  localparam int unsigned N     = k2red_num_digits(W, R);
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned PPW   = W + R;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SH_W  = $clog2(PW);

  // Reject configurations where Y does not split into whole digits
  if (((W % R) != 0) || (TAG_W == 0)) begin : g_bad_cfg
    $error("k2red_mul_iter: W must be a multiple of R and TAG_W nonzero");
  end

  k2red_mul_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [SH_W-1:0]  shamt;
  logic [R-1:0]     ydig;
  logic [PPW-1:0]   pp;
  logic             accept;
  logic             last_digit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin : next_state
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? MUL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/control decode; in_ready never depends on in_valid
  always_comb begin : ctrl_out
    in_ready   = 1'b0;
    accept     = 1'b0;
    last_digit = 1'b0;
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    accept     = in_valid && in_ready;
    last_digit = (state == MUL) && (cnt == CNT_W'(N - 1));
  end

  // Select current Y digit and align its partial product into the accumulator
  always_comb begin : datapath
    shamt   = SH_W'(cnt) * SH_W'(R);
    ydig    = R'(y_q >> shamt);
    acc_nxt = acc + (PW'(pp) << shamt);
  end

  k2red_mul_digit #(
    .W (W),
    .R (R)
  ) u_digit (
    .x      (x_q),
    .d      (ydig),
    .prod_c (pp)
  );

  // Operand, accumulator, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin : dp_reg
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      A         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= X;
        y_q <= Y;
        acc <= '0;
        cnt <= '0;
      end else if (state == MUL) begin
        acc <= acc_nxt;
        cnt <= last_digit ? '0 : cnt + CNT_W'(1);
      end

      // A loads on the last digit edge; accept in DONE drops out_valid
      if (last_digit) begin
        A         <= acc_nxt;
        out_valid <= 1'b1;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef K2RED_MUL_TAG_EN
  logic [TAG_W-1:0] tag_q;

  // Tag travels with its operand pair and is published together with A
  always_ff @(posedge clk or negedge rst_n) begin : tag_reg
    if (!rst_n) begin
      tag_q   <= '0;
      out_tag <= '0;
    end else begin
      if (accept)     tag_q   <= in_tag;
      if (last_digit) out_tag <= tag_q;
    end
  end
`endif

endmodule

// File: tb/tb_k2red_mul_iter.sv
// Self-checking bench for k2red_mul_iter (W=32, R=4).
// Table-driven single transactions, plus hand-written backpressure,
// back-to-back, reset-abort and tag sequences; results tracked by a
// scoreboard queue filled at each accept edge.
module tb_k2red_mul_iter;

  localparam int unsigned W     = 32;
  localparam int unsigned R     = 4;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned N     = W / R;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   X = '0;
  logic [W-1:0]   Y = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] A;
`ifdef K2RED_MUL_TAG_EN
  logic [TAG_W-1:0] in_tag = '0;
  logic [TAG_W-1:0] out_tag;
`endif

  always #5 clk = ~clk;

  k2red_mul_iter #(
    .W     (W),
    .R     (R),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef K2RED_MUL_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [7:0]  tag;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] a;
    string       name;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic drive_tag(input logic [7:0] tag);
`ifdef K2RED_MUL_TAG_EN
    in_tag = tag;
`else
    if (tag == 8'hFF) ; // tag sideband not built
`endif
  endtask

  task automatic push_exp(input logic [31:0] x, input logic [31:0] y, input logic [7:0] tag);
    exp_t e;
    e.a   = model(x, y);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: actual=output with empty scoreboard required=pending entry", name);
    end else begin
      errors = errors;
      e = sb.pop_front();
      check({name, "_sb_a"}, A, e.a);
`ifdef K2RED_MUL_TAG_EN
      check({name, "_sb_tag"}, 64'(out_tag), 64'(e.tag));
`endif
    end
  endtask

  // One transaction from IDLE with out_ready high; called at a negedge
  task automatic run_single(input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp_a, input logic [7:0] tag,
                            input string name);
    int lat;
    lat = 0;
    @(negedge clk);
    X = x; Y = y; in_valid = 1'b1; out_ready = 1'b1;
    drive_tag(tag);
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    push_exp(x, y, tag);
    @(negedge clk);
    in_valid = 1'b0;
    X = ~x; Y = ~y;  // latched operands must be used, not the live bus
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, "_latency"}, 64'(lat), 64'(N));
    check({name, "_a"}, A, exp_a);
    check({name, "_in_ready_done"}, 64'(in_ready), 64'd1);
`ifdef K2RED_MUL_TAG_EN
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
`endif
    sb_pop_check(name);
    @(negedge clk);
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  vec_t        vecs[7];
  logic [31:0] bx[3];
  logic [31:0] by[3];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, ry;
    int transfers, prev, seen;

    rx = $urandom;
    ry = $urandom;
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max"};
    vecs[1] = '{32'h0001_E001, 32'h0000_0000, 64'h0, "y_zero"};
    vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0, "x_zero"};
    vecs[3] = '{32'h0000_0001, 32'h8000_0001, 64'h8000_0001, "x_one"};
    vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, "mixed"};
    vecs[5] = '{32'h0000_000F, 32'h0000_000F, 64'hE1, "small"};
    vecs[6] = '{rx, ry, model(rx, ry), "random"};
    bx = '{32'hCAFE_F00D, 32'h0000_0003, 32'h8000_0000};
    by = '{32'h1357_9BDF, 32'hFFFF_FFFF, 32'h0000_0002};

    // Reset state
    #12;
    check("rst_a", A, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Table of single transactions
    for (int i = 0; i < 7; i++)
      run_single(vecs[i].x, vecs[i].y, vecs[i].a, 8'(i + 1), vecs[i].name);

    // Backpressure: product held while out_ready low
    @(negedge clk);
    X = 32'h1234_5678; Y = 32'h9ABC_DEF0; in_valid = 1'b1; out_ready = 1'b0;
    drive_tag(8'h33);
    @(posedge clk);
    push_exp(32'h1234_5678, 32'h9ABC_DEF0, 8'h33);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("bp_valid_rise", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_a", A, 64'h0B00_EA4E_242D_2080);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 64'(in_ready), 64'd1);
    sb_pop_check("bp");
    @(negedge clk);
    check("bp_single_transfer", 64'(out_valid), 64'd0);

    // Back-to-back stream with in_valid/out_ready held high.
    // The accept for the next pair happens on the edge leaving DONE,
    // so products are spaced N+1 edges apart.
    transfers = 0;
    prev = -1;
    fork
      begin : drv
        int guard;
        for (int i = 0; i < 3; i++) begin
          X = bx[i]; Y = by[i]; in_valid = 1'b1;
          drive_tag(8'(8'h80 + i));
          guard = 0;
          while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
          end
          @(posedge clk);
          push_exp(bx[i], by[i], 8'(8'h80 + i));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : mon
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            transfers++;
            sb_pop_check("b2b");
            if (prev >= 0) check("b2b_spacing", 64'(c - prev), 64'(N + 1));
            prev = c;
          end
        end
      end
    join
    check("b2b_count", 64'(transfers), 64'd3);
    check("b2b_sb_drained", 64'(sb.size()), 64'd0);

    // Reset asserted in the middle of MUL
    @(negedge clk);
    X = 32'hFFFF_0000; Y = 32'h0000_FFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("rstmid_a_before", A, model(bx[2], by[2]));
    rst_n = 1'b0;
    #1;
    check("rstmid_a", A, 64'd0);
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstmid_no_phantom", 64'(seen), 64'd0);
    run_single(32'h0BAD_F00D, 32'h0000_1234, model(32'h0BAD_F00D, 32'h0000_1234),
               8'h11, "after_rst");

    // Consecutive tagged pairs
    run_single(32'h0000_1111, 32'h0000_2222, model(32'h0000_1111, 32'h0000_2222),
               8'h5A, "tag5a");
    run_single(32'h0000_3333, 32'h0000_4444, model(32'h0000_3333, 32'h0000_4444),
               8'hA5, "taga5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
